mdu_sequencer: RTL and testbench

Multi-cycle unsigned multiply/divide sequencer for the MIPS datapath. It implements MULTU and DIVU by iterating a shared 32-bit ALU instance for 32 cycles: shift-add for multiply, restoring subtract for divide. It owns the HI/LO result registers. It sits beside the execute-stage ALU and drives that ALU's control and operand inputs while Busy is high.

---
 rtl/mdu_sequencer.sv | 151 +++++++++++++++
 tb/tb_mdu_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
`default_nettype none
// ============================================================================
// mdu_sequencer: 32-step unsigned MULTU/DIVU engine driving a shared ALU; owns HI/LO.
// DIVU support is built only when MDU_DIVU_EN is defined.   Rev 1.0
// ============================================================================
module mdu_sequencer #(
  parameter int BITS_SIZE = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Op,
  input  logic [BITS_SIZE-1:0] Rs,
  input  logic [BITS_SIZE-1:0] Rt,
  output logic                 Busy,
  output logic                 Done,
  output logic [BITS_SIZE-1:0] Hi,
  output logic [BITS_SIZE-1:0] Lo,
  output logic [3:0]           AluControl,
  output logic [BITS_SIZE-1:0] AluA,
  output logic [BITS_SIZE-1:0] AluB,
  input  logic [BITS_SIZE-1:0] AluResult
);

  localparam int         CNT_W   = $clog2(BITS_SIZE) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BITS_SIZE - 1);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [BITS_SIZE-1:0] hi_reg;
  logic [BITS_SIZE-1:0] lo_reg;
  logic [BITS_SIZE-1:0] m_reg;
  logic [BITS_SIZE-1:0] hi_step;
  logic [BITS_SIZE-1:0] lo_step;
  logic                 carry;
  logic                 accept_run;

`ifdef MDU_DIVU_EN
  logic                 op_reg;
  logic                 ge;
  logic [BITS_SIZE:0]   rem;

  assign rem        = {hi_reg, lo_reg[BITS_SIZE-1]};
  assign accept_run = (state == S_IDLE) && Start;
`else
  // Without the divider a DIVU request is acknowledged but never iterates.
  assign accept_run = (state == S_IDLE) && Start && !Op;
`endif

  assign Hi = hi_reg;
  assign Lo = lo_reg;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept_run) begin
          state_nxt = S_RUN;
        end else if (Start) begin
          state_nxt = S_DONE;
        end
      end
      S_RUN: begin
        if (cnt == LAST_CNT) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    Busy       = (state == S_RUN);
    Done       = (state == S_DONE);
    AluControl = ALU_AND;
    AluA       = '0;
    AluB       = '0;
    if (state == S_RUN) begin
`ifdef MDU_DIVU_EN
      if (op_reg) begin
        AluControl = ALU_SUB;
        AluA       = rem[BITS_SIZE-1:0];
        AluB       = m_reg;
      end else
`endif
      begin
        AluControl = ALU_ADD;
        AluA       = hi_reg;
        AluB       = lo_reg[0] ? m_reg : '0;
      end
    end
  end

  // Multiply: a wrapped sum is smaller than its addend, which recovers the carry.
  always_comb begin
    carry   = (AluResult < hi_reg);
    hi_step = {carry, AluResult[BITS_SIZE-1:1]};
    lo_step = {AluResult[0], lo_reg[BITS_SIZE-1:1]};
`ifdef MDU_DIVU_EN
    ge = rem[BITS_SIZE] | (rem[BITS_SIZE-1:0] >= m_reg);
    if (op_reg) begin
      hi_step = ge ? AluResult : rem[BITS_SIZE-1:0];
      lo_step = {lo_reg[BITS_SIZE-2:0], ge};
    end
`endif
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt    <= '0;
      hi_reg <= '0;
      lo_reg <= '0;
      m_reg  <= '0;
`ifdef MDU_DIVU_EN
      op_reg <= 1'b0;
`endif
    end else if (accept_run) begin
      cnt    <= '0;
      hi_reg <= '0;
`ifdef MDU_DIVU_EN
      op_reg <= Op;
      m_reg  <= Op ? Rt : Rs;
      lo_reg <= Op ? Rs : Rt;
`else
      m_reg  <= Rs;
      lo_reg <= Rt;
`endif
    end else if (state == S_RUN) begin
      cnt    <= cnt + CNT_W'(1);
      hi_reg <= hi_step;
      lo_reg <= lo_step;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
`default_nettype none
// ============================================================================
// tb_mdu_sequencer: vector table, random ops vs. arithmetic model, corner sequences.
// ============================================================================
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] rs = '0;
  logic [31:0] rt = '0;
  logic        busy, done;
  logic [31:0] hi, lo, alu_a, alu_b;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[$];

  mdu_sequencer #(.BITS_SIZE(32)) dut (
    .Clk(clk), .Reset(rst), .Start(start), .Op(op), .Rs(rs), .Rt(rt),
    .Busy(busy), .Done(done), .Hi(hi), .Lo(lo),
    .AluControl(alu_control), .AluA(alu_a), .AluB(alu_b), .AluResult(alu_result)
  );

  always #5 clk = ~clk;

  // Shared execute-stage ALU
  always_comb begin
    case (alu_control)
      4'd2:    alu_result = alu_a + alu_b;
      4'd6:    alu_result = alu_a - alu_b;
      default: alu_result = alu_a & alu_b;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model(input logic o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el);
    logic [63:0] p;
    if (!o) begin
      p  = {32'd0, a} * {32'd0, b};
      eh = p[63:32];
      el = p[31:0];
    end else if (b == 0) begin
      eh = a;
      el = 32'hFFFF_FFFF;
    end else begin
      eh = a % b;
      el = a / b;
    end
  endtask

  // Issue one operation from IDLE and return in the first IDLE cycle after Done.
  // repulse_at > 0 re-pulses Start at that RUN cycle and again in the DONE cycle.
  task automatic run_op(input string name, input logic o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh,
                        input logic [31:0] el, input int repulse_at);
    int cyc;
    bit ctl_ok;
    @(negedge clk);
    start = 1'b1; op = o; rs = a; rt = b;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    ctl_ok = 1'b1;
    while (!done && cyc < 40) begin
      if (!busy || alu_control !== (o ? 4'd6 : 4'd2)) ctl_ok = 1'b0;
      if (repulse_at > 0) begin
        start = (cyc == repulse_at);
        op = ~o; rs = 32'h55; rt = 32'h66;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    chk({name, " latency"}, 64'(cyc), 64'd33);
    chk({name, " busy/ctl in run"}, 64'(ctl_ok), 64'd1);
    chk({name, " busy low at done"}, 64'(busy), 64'd0);
    chk({name, " alu idle at done"}, {alu_control, alu_a, alu_b} & 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    chk({name, " hi"}, 64'(hi), 64'(eh));
    chk({name, " lo"}, 64'(lo), 64'(el));
    if (repulse_at > 0) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({name, " done one cycle"}, {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    logic [31:0] eh, el, a, b;
    logic        o;
    int          cyc;
    bit          saw_done;

    vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{1'b0, 32'd3,         32'd4,         32'd0,         32'd12});
    vecs.push_back('{1'b0, 32'h8000_0000, 32'd2,         32'd1,         32'd0});
    vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'd2,         32'd1,         32'hFFFF_FFFE});
    vecs.push_back('{1'b0, 32'd0,         32'hDEAD_BEEF, 32'd0,         32'd0});
    vecs.push_back('{1'b0, 32'd1,         32'hDEAD_BEEF, 32'd0,         32'hDEAD_BEEF});
    vecs.push_back('{1'b0, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0});
`ifdef MDU_DIVU_EN
    vecs.push_back('{1'b1, 32'd100,       32'd7,         32'd2,         32'd14});
    vecs.push_back('{1'b1, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF});
    vecs.push_back('{1'b1, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF});
    vecs.push_back('{1'b1, 32'd7,         32'd100,       32'd7,         32'd0});
    vecs.push_back('{1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1});
`endif

    #1;
    chk("reset busy/done", {62'd0, busy, done}, 64'd0);
    chk("reset hi/lo", {hi, lo}, 64'd0);
    chk("reset alu", {28'd0, alu_control, alu_a} | 64'(alu_b), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
             vecs[i].exp_hi, vecs[i].exp_lo, 0);

    // Start re-pulsed mid-run and during Done is ignored; next IDLE start is taken
    run_op("repulse 3x4", 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 10);

`ifndef MDU_DIVU_EN
    // DIVU without the divider: Done next cycle, no Busy, Hi/Lo untouched
    @(negedge clk);
    start = 1'b1; op = 1'b1; rs = 32'd100; rt = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    chk("nodiv done/busy", {62'd0, done, busy}, 64'd2);
    chk("nodiv hi/lo", {hi, lo}, {32'd0, 32'd12});
    @(posedge clk); #1;
    chk("nodiv back idle", {62'd0, done, busy}, 64'd0);
`endif

    model(1'b0, 32'd6, 32'd7, eh, el);
    run_op("back2back", 1'b0, 32'd6, 32'd7, eh, el, 0);

    for (int n = 0; n < 24; n++) begin
      a = $urandom;
      b = (n % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
`ifdef MDU_DIVU_EN
      o = 1'($urandom_range(0, 1));
`else
      o = 1'b0;
`endif
      model(o, a, b, eh, el);
      run_op($sformatf("rand%0d op%0d %0h,%0h", n, o, a, b), o, a, b, eh, el, 0);
    end

    // Asynchronous reset partway through an operation
    @(negedge clk);
`ifdef MDU_DIVU_EN
    start = 1'b1; op = 1'b1; rs = 32'hFFFF_FFF0; rt = 32'd3;
`else
    start = 1'b1; op = 1'b0; rs = 32'hFFFF_FFFF; rt = 32'hFFFF_FFFF;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async rst busy/done", {62'd0, busy, done}, 64'd0);
    chk("async rst hi/lo", {hi, lo}, 64'd0);
    chk("async rst alu", {28'd0, alu_control, alu_a} | 64'(alu_b), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("no done after rst", 64'(saw_done), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
